ebr_bist: RTL

EBR_BIST -- requirements
Module: ebr_bist

---
 rtl/ebr_bist.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ebr_bist.sv
// March-style BIST for an attached EBR port: write addr^SEED everywhere, read it back, count mismatches.
// Define EBR_BIST_INV_PASS_EN to add a second pass that uses the complemented pattern.
module ebr_bist #(
  parameter string             REGMODE = "NOREG",
  parameter int                ADDR_W  = 10,
  parameter int                DATA_W  = 9,
  parameter logic [DATA_W-1:0] SEED    = 9'h155
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [ADDR_W-1:0] FAIL_ADDR,
  output logic [7:0]        ERR_CNT,
  output logic [ADDR_W-1:0] AD,
  output logic [DATA_W-1:0] DI,
  output logic              WE,
  output logic              CE,
  output logic              OCE,
  input  logic [DATA_W-1:0] DO
);

  localparam int                LAT      = (REGMODE == "OUTREG") ? 2 : 1;
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_dcnt;
  logic [7:0]        r_err;
  logic [ADDR_W-1:0] r_fail;
  logic [LAT-1:0]    r_vld_p;
  logic [DATA_W-1:0] r_exp_p [LAT];
  logic [ADDR_W-1:0] r_adr_p [LAT];
  logic              w_issue;
  logic              w_start_ok;
  logic              w_last_pass;
  logic              w_cmp_mis;
  logic [DATA_W-1:0] w_pat;

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

`ifdef EBR_BIST_INV_PASS_EN
  logic r_inv;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      r_inv <= 1'b0;
    else if (w_start_ok)
      r_inv <= 1'b0;
    else if (r_state == S_DRAIN && w_next == S_WRITE)
      r_inv <= 1'b1;
  end

  assign w_pat       = (r_addr[DATA_W-1:0] ^ SEED) ^ {DATA_W{r_inv}};
  assign w_last_pass = r_inv;
`else
  assign w_pat       = r_addr[DATA_W-1:0] ^ SEED;
  assign w_last_pass = 1'b1;
`endif

  assign w_start_ok = START && (r_state == S_IDLE || r_state == S_DONE);
  assign w_cmp_mis  = r_vld_p[LAT-1] && (DO != r_exp_p[LAT-1]);
  assign OCE        = BUSY;
  assign PASS       = DONE && (r_err == 8'd0);
  assign ERR_CNT    = r_err;
  assign FAIL_ADDR  = r_fail;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    BUSY    = 1'b0;
    DONE    = 1'b0;
    WE      = 1'b0;
    CE      = 1'b0;
    AD      = '0;
    DI      = '0;
    w_issue = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) w_next = S_WRITE;
      end
      S_WRITE: begin
        BUSY = 1'b1;
        WE   = 1'b1;
        CE   = 1'b1;
        AD   = r_addr;
        DI   = w_pat;
        if (r_addr == ADDR_MAX) w_next = S_READ;
      end
      S_READ: begin
        BUSY    = 1'b1;
        CE      = 1'b1;
        AD      = r_addr;
        w_issue = 1'b1;
        if (r_addr == ADDR_MAX) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        BUSY = 1'b1;
        if (r_dcnt == 2'(LAT - 1)) w_next = w_last_pass ? S_DONE : S_WRITE;
      end
      S_DONE: begin
        DONE = 1'b1;
        if (START) w_next = S_WRITE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_addr <= '0;
      r_dcnt <= '0;
      r_err  <= '0;
      r_fail <= '0;
    end else if (w_start_ok) begin
      r_addr <= '0;
      r_dcnt <= '0;
      r_err  <= '0;
      r_fail <= '0;
    end else begin
      // The address counter wraps naturally from ADDR_MAX back to 0 at every phase change.
      if (r_state == S_WRITE || r_state == S_READ)
        r_addr <= r_addr + 1'b1;
      r_dcnt <= (r_state == S_DRAIN) ? r_dcnt + 2'd1 : 2'd0;
      if (w_cmp_mis) begin
        r_err <= sat_inc(r_err);
        if (r_err == 8'd0) r_fail <= r_adr_p[LAT-1];
      end
    end
  end

  // Compare pipeline: p0 is loaded at read issue, stage LAT-1 lines up with DO.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_vld_p <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_exp_p[i] <= '0;
        r_adr_p[i] <= '0;
      end
    end else begin
      r_vld_p[0] <= w_issue;
      r_exp_p[0] <= w_pat;
      r_adr_p[0] <= r_addr;
      for (int i = 1; i < LAT; i++) begin
        r_vld_p[i] <= r_vld_p[i-1];
        r_exp_p[i] <= r_exp_p[i-1];
        r_adr_p[i] <= r_adr_p[i-1];
      end
    end
  end

endmodule
